// File: rtl/branch_pkg.sv
// Shared definitions for the branch-condition evaluator: opcode field layout,
// the BR class constant and the condition-code enumeration.
package branch_pkg;

  localparam int unsigned OPC_W   = 18;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 5;

  // Opcode field slice positions
  localparam int unsigned CLASS_MSB = 17;
  localparam int unsigned CLASS_LSB = 12;
  localparam int unsigned COND_MSB  = 11;
  localparam int unsigned COND_LSB  = 8;

  localparam int unsigned CLASS_W = CLASS_MSB - CLASS_LSB + 1;
  localparam int unsigned COND_W  = COND_MSB - COND_LSB + 1;

  localparam logic [CLASS_W-1:0] BR_CLASS = 6'b000100;

  typedef enum logic [COND_W-1:0] {
    COND_BEQZ = 4'd0,
    COND_BNEZ = 4'd1,
    COND_BLTZ = 4'd2,
    COND_BGEZ = 4'd3,
    COND_BGTZ = 4'd4,
    COND_BLEZ = 4'd5,
    COND_BBS  = 4'd6,
    COND_BBC  = 4'd7,
    COND_BAL  = 4'd8
  } cond_e;

  function automatic logic [CLASS_W-1:0] get_class(input logic [OPC_W-1:0] opc);
    return opc[CLASS_MSB:CLASS_LSB];
  endfunction

  function automatic logic [COND_W-1:0] get_cond(input logic [OPC_W-1:0] opc);
    return opc[COND_MSB:COND_LSB];
  endfunction

endpackage

// File: rtl/branch_ins_mod_1_if.sv
// Operand/opcode bundle feeding the branch evaluator and its registered taken flag.
interface branch_ins_mod_1_if;
  import branch_pkg::*;

  logic [OPC_W-1:0]  opc_in;
  logic [DATA_W-1:0] RF_in;
  logic [IDX_W-1:0]  RS_val;
  logic              out_bit;

  modport master (
    output opc_in,
    output RF_in,
    output RS_val,
    input  out_bit
  );

  modport slave (
    input  opc_in,
    input  RF_in,
    input  RS_val,
    output out_bit
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition test: sign, zero or single-bit tests
// on the register operand, selected by the condition code.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [COND_W-1:0] i_cond,
  input  logic [DATA_W-1:0] i_operand,
  input  logic [IDX_W-1:0]  i_bit_idx,
  output logic              o_taken
);

  logic w_zero;
  logic w_neg;
  logic w_sel_bit;

  assign w_zero    = (i_operand == '0);
  assign w_neg     = i_operand[DATA_W-1];
  assign w_sel_bit = i_operand[i_bit_idx];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_BEQZ: o_taken = w_zero;
      COND_BNEZ: o_taken = ~w_zero;
      COND_BLTZ: o_taken = w_neg;
      COND_BGEZ: o_taken = ~w_neg;
      COND_BGTZ: o_taken = ~w_neg & ~w_zero;
      COND_BLEZ: o_taken = w_neg | w_zero;
      COND_BBS:  o_taken = w_sel_bit;
      COND_BBC:  o_taken = ~w_sel_bit;
      COND_BAL:  o_taken = 1'b1;
      // Codes 9-15 are reserved and never taken
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ins_mod_1.sv
// Branch-condition evaluator top: gates the condition result on the BR class
// and registers the taken flag for the fetch stage's next-PC select.
module branch_ins_mod_1
  import branch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  branch_ins_mod_1_if.slave     bus
);

  logic              w_is_br;
  logic              w_cond_taken;
  logic              w_taken;
  logic              r_out_bit;
  logic              w_unused_opc;

  assign w_is_br = (get_class(bus.opc_in) == BR_CLASS);

  branch_cond_eval u_cond_eval (
    .i_cond    (get_cond(bus.opc_in)),
    .i_operand (bus.RF_in),
    .i_bit_idx (bus.RS_val),
    .o_taken   (w_cond_taken)
  );

  assign w_taken = w_is_br & w_cond_taken;

  // Low opcode byte carries no branch information
  assign w_unused_opc = ^bus.opc_in[COND_LSB-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_bit <= 1'b0;
    end else begin
      r_out_bit <= w_taken;
    end
  end

  assign bus.out_bit = r_out_bit;

endmodule

// File: tb/tb_branch_ins_mod_1.sv
// Directed self-checking bench for branch_ins_mod_1 with hand-computed expectations.
module tb_branch_ins_mod_1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  branch_ins_mod_1_if bus ();

  branch_ins_mod_1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mk(input logic [5:0] cls, input logic [3:0] cc,
                                     input logic [7:0] low);
    return {cls, cc, low};
  endfunction

  task automatic check(input string tag, input logic exp);
    checks++;
    assert (bus.out_bit === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, bus.out_bit, exp);
    end
  endtask

  // Drive between edges, capture on the next rising edge, sample 1 time unit later.
  task automatic step(input string tag, input logic [17:0] opc, input logic [31:0] rf,
                      input logic [4:0] rs, input logic exp);
    bus.opc_in = opc;
    bus.RF_in  = rf;
    bus.RS_val = rs;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  localparam logic [5:0] BR = 6'b000100;

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    bus.opc_in = '0;
    bus.RF_in  = '0;
    bus.RS_val = '0;

    #2;
    check("reset_async", 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", 1'b0);
    #2;
    rst_n = 1'b1;

    step("idle_zero_opc", 18'h0, 32'h0, 5'd0, 1'b0);

    // Bit-test conditions, RF_in = 10 = 0b1010
    step("bbs_bit10", mk(BR, 4'd6, 8'h00), 32'd10, 5'd10, 1'b0);
    step("bbs_bit3",  mk(BR, 4'd6, 8'h00), 32'd10, 5'd3,  1'b1);
    step("bbs_bit4",  mk(BR, 4'd6, 8'h00), 32'd10, 5'd4,  1'b0);
    step("bbc_bit1",  mk(BR, 4'd7, 8'h00), 32'd10, 5'd1,  1'b0);
    step("bbc_bit31", mk(BR, 4'd7, 8'h00), 32'd10, 5'd31, 1'b1);
    step("bbs_bit31", mk(BR, 4'd6, 8'h00), 32'h8000_0000, 5'd31, 1'b1);
    step("bbs_bit0",  mk(BR, 4'd6, 8'h00), 32'h0000_0001, 5'd0,  1'b1);

    // Sign/zero conditions; RS_val set to non-zero to show it is ignored
    step("beqz_zero", mk(BR, 4'd0, 8'h00), 32'h0, 5'd7, 1'b1);
    step("bnez_zero", mk(BR, 4'd1, 8'h00), 32'h0, 5'd7, 1'b0);
    step("bgtz_zero", mk(BR, 4'd2 + 4'd2, 8'h00), 32'h0, 5'd7, 1'b0);
    step("blez_zero", mk(BR, 4'd5, 8'h00), 32'h0, 5'd7, 1'b1);
    step("bltz_neg1", mk(BR, 4'd2, 8'h00), 32'hFFFF_FFFF, 5'd0, 1'b1);
    step("bgez_neg1", mk(BR, 4'd3, 8'h00), 32'hFFFF_FFFF, 5'd0, 1'b0);
    step("bgtz_max",  mk(BR, 4'd4, 8'h00), 32'h7FFF_FFFF, 5'd0, 1'b1);
    step("beqz_one",  mk(BR, 4'd0, 8'h00), 32'h1, 5'd0, 1'b0);
    step("bnez_neg",  mk(BR, 4'd1, 8'h00), 32'h8000_0000, 5'd0, 1'b1);
    step("blez_neg",  mk(BR, 4'd5, 8'h00), 32'h8000_0000, 5'd0, 1'b1);
    step("blez_pos",  mk(BR, 4'd5, 8'h00), 32'h0000_0005, 5'd0, 1'b0);
    step("bgez_zero", mk(BR, 4'd3, 8'h00), 32'h0, 5'd0, 1'b1);
    step("bltz_pos",  mk(BR, 4'd2, 8'h00), 32'h7FFF_FFFF, 5'd0, 1'b0);

    // BAL always taken, low byte ignored
    step("bal_zero",  mk(BR, 4'd8, 8'h00), 32'h0, 5'd0, 1'b1);
    step("bal_junk",  mk(BR, 4'd8, 8'hA5), 32'hDEAD_BEEF, 5'd13, 1'b1);

    // Reserved codes and wrong class
    step("rsv_code9",  mk(BR, 4'd9,  8'h00), 32'h0, 5'd0, 1'b0);
    step("rsv_code15", mk(BR, 4'd15, 8'hFF), 32'hFFFF_FFFF, 5'd31, 1'b0);
    step("cls5_bal",   mk(6'b000101, 4'd8, 8'h00), 32'h0, 5'd0, 1'b0);
    step("cls0_beqz",  mk(6'b000000, 4'd0, 8'h00), 32'h0, 5'd0, 1'b0);
    step("cls3f_bnez", mk(6'b111111, 4'd1, 8'h00), 32'h1, 5'd0, 1'b0);

    // Input change between edges does not move the registered output
    step("hold_pre",  mk(BR, 4'd8, 8'h00), 32'h0, 5'd0, 1'b1);
    #2;
    bus.opc_in = 18'h0;
    #1;
    check("hold_between_edges", 1'b1);
    @(posedge clk);
    #1;
    check("hold_next_edge", 1'b0);

    // Mid-stream asynchronous reset while out_bit is 1
    step("mid_pre", mk(BR, 4'd8, 8'h00), 32'h0, 5'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", 1'b0);
    @(posedge clk);
    #1;
    check("mid_reset_held", 1'b0);
    #2;
    rst_n = 1'b1;
    step("post_reset_bal", mk(BR, 4'd8, 8'h00), 32'h0, 5'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
